// File: rtl/lsu_bus_master_pkg.sv
// Shared types and helpers for the load/store bus master.
//   lsu_state_t   : transaction FSM states
//   LSU_*         : funct3 access size/sign encodings
//   lsu_req_legal : returns 1 when a request may go on the bus
package lsu_bus_master_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } lsu_state_t;

    localparam logic [2:0] LSU_B  = 3'b000;
    localparam logic [2:0] LSU_H  = 3'b001;
    localparam logic [2:0] LSU_W  = 3'b010;
    localparam logic [2:0] LSU_BU = 3'b100;
    localparam logic [2:0] LSU_HU = 3'b101;

    // Unsigned sizes exist only for loads. Halfwords need an even offset,
    // words a zero offset. A simultaneous load and store is never legal.
    function automatic logic lsu_req_legal(
        input logic       rden,
        input logic       wren,
        input logic [2:0] f3,
        input logic [1:0] off
    );
        logic size_ok;
        logic align_ok;
        size_ok  = 1'b0;
        align_ok = 1'b1;
        case (f3)
            LSU_B:  size_ok = 1'b1;
            LSU_H:  begin size_ok = 1'b1; align_ok = ~off[0];        end
            LSU_W:  begin size_ok = 1'b1; align_ok = (off == 2'b00); end
            LSU_BU: size_ok = rden;
            LSU_HU: begin size_ok = rden; align_ok = ~off[0];        end
            default: size_ok = 1'b0;
        endcase
        return ~(rden & wren) & size_ok & align_ok;
    endfunction

endpackage

// File: rtl/lsu_bus_master_load_align.sv
// Load data alignment and extension (purely combinational).
//   rdata_i  : 32-bit word returned by the bus
//   offset_i : byte offset of the access within the word
//   funct3_i : access size/sign
//   data_o   : selected byte/halfword, sign- or zero-extended; words pass through
module lsu_load_align
    import lsu_bus_master_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  offset_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata_i[{offset_i, 3'b000} +: 8];
        half_sel = rdata_i[{offset_i[1], 4'b0000} +: 16];
        case (funct3_i)
            LSU_B:   data_o = {{24{byte_sel[7]}}, byte_sel};
            LSU_H:   data_o = {{16{half_sel[15]}}, half_sel};
            LSU_BU:  data_o = {24'd0, byte_sel};
            LSU_HU:  data_o = {16'd0, half_sel};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/lsu_bus_master.sv
// Data-memory access stage: turns control-unit load/store requests into a
// req/ready bus transaction and stalls the core until it retires.
//   clk, rst            : clock (rising edge), async active-low reset
//   req_rden, req_wren  : load / store request
//   funct3, addr, wdata : access size/sign, byte address, store data
//   stall               : hold PC and rf_wren while a transaction is pending
//   ld_data, ld_valid   : extended load result, valid in the completion cycle
//   fault               : one-cycle pulse on illegal request or bus timeout
//   bus_*               : word-addressed bus with byte enables
module lsu_bus_master
    import lsu_bus_master_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_rden,
    input  logic        req_wren,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic [31:0] ld_data,
    output logic        ld_valid,
    output logic        fault,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ready
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    lsu_state_t        state_q, state_d;
    logic [31:0]       addr_q, addr_d;
    logic [2:0]        f3_q, f3_d;
    logic              we_q, we_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       ld_data_q, ld_data_d;

    logic              req_any;
    logic              req_ok;
    logic [3:0]        be_new;
    logic [31:0]       wdata_new;
    logic [31:0]       ld_aligned;

    lsu_load_align u_align (
        .rdata_i  (bus_rdata),
        .offset_i (addr_q[1:0]),
        .funct3_i (f3_q),
        .data_o   (ld_aligned)
    );

    assign req_any = req_rden | req_wren;
    assign req_ok  = lsu_req_legal(req_rden, req_wren, funct3, addr[1:0]);

    // Lane steering for the incoming request; funct3[1:0] carries the size.
    always_comb begin
        case (funct3[1:0])
            2'b00: begin
                be_new    = 4'b0001 << addr[1:0];
                wdata_new = {4{wdata[7:0]}};
            end
            2'b01: begin
                be_new    = 4'b0011 << addr[1:0];
                wdata_new = {2{wdata[15:0]}};
            end
            default: begin
                be_new    = 4'b1111;
                wdata_new = wdata;
            end
        endcase
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        f3_d      = f3_q;
        we_d      = we_q;
        be_d      = be_q;
        wdata_d   = wdata_q;
        cnt_d     = cnt_q;
        ld_data_d = ld_data_q;
        stall     = 1'b0;

        case (state_q)
            IDLE: begin
                // rst gate keeps stall low while reset holds a pending request
                if (req_any && rst) begin
                    stall = 1'b1;
                    if (req_ok) begin
                        addr_d  = addr;
                        f3_d    = funct3;
                        we_d    = req_wren;
                        be_d    = be_new;
                        wdata_d = wdata_new;
                        cnt_d   = '0;
                        state_d = BUSY;
                    end else begin
                        state_d = ERR;
                    end
                end
            end
            BUSY: begin
                stall = 1'b1;
                // ready is checked first so it wins over a same-cycle timeout
                if (bus_ready) begin
                    if (!we_q) ld_data_d = ld_aligned;
                    cnt_d   = '0;
                    state_d = DONE;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = ERR;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            f3_q      <= '0;
            we_q      <= 1'b0;
            be_q      <= '0;
            wdata_q   <= '0;
            cnt_q     <= '0;
            ld_data_q <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            f3_q      <= f3_d;
            we_q      <= we_d;
            be_q      <= be_d;
            wdata_q   <= wdata_d;
            cnt_q     <= cnt_d;
            ld_data_q <= ld_data_d;
        end
    end

    // Bus fields are driven only while the request is up so the bus reads idle otherwise.
    assign bus_req   = (state_q == BUSY);
    assign bus_we    = bus_req & we_q;
    assign bus_addr  = bus_req ? {addr_q[31:2], 2'b00} : '0;
    assign bus_be    = bus_req ? be_q : '0;
    assign bus_wdata = bus_req ? wdata_q : '0;
    assign ld_valid  = (state_q == DONE) & ~we_q;
    assign ld_data   = ld_data_q;
    assign fault     = (state_q == ERR);

endmodule

// File: tb/tb_lsu_bus_master.sv
module tb_lsu_bus_master;

    logic        clk;
    logic        rst;
    logic        req_rden;
    logic        req_wren;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic [31:0] ld_data;
    logic        ld_valid;
    logic        fault;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ready;

    int total = 0;
    int bad   = 0;

    lsu_bus_master #(.TIMEOUT(4), .CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_rden  (req_rden),
        .req_wren  (req_wren),
        .funct3    (funct3),
        .addr      (addr),
        .wdata     (wdata),
        .stall     (stall),
        .ld_data   (ld_data),
        .ld_valid  (ld_valid),
        .fault     (fault),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_be    (bus_be),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .bus_ready (bus_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    // Legal transaction: one IDLE cycle, waits+1 BUSY cycles, one DONE cycle.
    task automatic xfer(input string tag, input logic rd, input logic wr,
                        input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] rdv, input int unsigned waits,
                        input logic [31:0] e_addr, input logic [3:0] e_be,
                        input logic [31:0] e_wd, input logic [31:0] e_ld);
        @(negedge clk);
        req_rden = rd; req_wren = wr; funct3 = f3; addr = a; wdata = wd;
        bus_ready = 1'b0; bus_rdata = '0;
        #1;
        chk({tag, "/idle_stall"}, stall, 1);
        chk({tag, "/idle_req"}, bus_req, 0);
        for (int unsigned i = 0; i <= waits; i++) begin
            @(negedge clk);
            bus_ready = (i == waits);
            bus_rdata = (i == waits) ? rdv : 32'h0;
            #1;
            chk({tag, "/busy_req"}, bus_req, 1);
            chk({tag, "/busy_stall"}, stall, 1);
            chk({tag, "/busy_addr"}, bus_addr, e_addr);
            chk({tag, "/busy_we"}, bus_we, wr);
            if (wr) begin
                chk({tag, "/busy_be"}, bus_be, e_be);
                chk({tag, "/busy_wdata"}, bus_wdata, e_wd);
            end
        end
        @(negedge clk);
        req_rden = 1'b0; req_wren = 1'b0; bus_ready = 1'b0; bus_rdata = '0;
        #1;
        chk({tag, "/done_stall"}, stall, 0);
        chk({tag, "/done_req"}, bus_req, 0);
        chk({tag, "/done_fault"}, fault, 0);
        chk({tag, "/done_valid"}, ld_valid, rd);
        if (rd) chk({tag, "/done_ld"}, ld_data, e_ld);
    endtask

    // Illegal request: IDLE stalls, ERR pulses fault, then back to IDLE; never a bus request.
    task automatic illegal(input string tag, input logic rd, input logic wr,
                           input logic [2:0] f3, input logic [31:0] a);
        @(negedge clk);
        req_rden = rd; req_wren = wr; funct3 = f3; addr = a; wdata = 32'h5555AAAA;
        #1;
        chk({tag, "/idle_stall"}, stall, 1);
        chk({tag, "/idle_req"}, bus_req, 0);
        @(negedge clk);
        req_rden = 1'b0; req_wren = 1'b0;
        #1;
        chk({tag, "/err_fault"}, fault, 1);
        chk({tag, "/err_stall"}, stall, 0);
        chk({tag, "/err_req"}, bus_req, 0);
        chk({tag, "/err_valid"}, ld_valid, 0);
        @(negedge clk);
        #1;
        chk({tag, "/after_fault"}, fault, 0);
        chk({tag, "/after_req"}, bus_req, 0);
    endtask

    initial begin
        rst = 1'b0; req_rden = 1'b0; req_wren = 1'b0; funct3 = 3'b000;
        addr = '0; wdata = '0; bus_rdata = '0; bus_ready = 1'b0;
        #12;
        chk("rst/stall", stall, 0);
        chk("rst/bus_req", bus_req, 0);
        chk("rst/ld_valid", ld_valid, 0);
        chk("rst/fault", fault, 0);
        chk("rst/ld_data", ld_data, 32'h0);
        chk("rst/bus_addr", bus_addr, 32'h0);
        @(negedge clk);
        rst = 1'b1;

        xfer("sw",  1'b0, 1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0, 0,
             32'h0000_0100, 4'b1111, 32'hDEAD_BEEF, 32'h0);
        xfer("lb",  1'b1, 1'b0, 3'b000, 32'h0000_0203, 32'h0, 32'h80FF_7F01, 0,
             32'h0000_0200, 4'b0000, 32'h0, 32'hFFFF_FF80);
        @(negedge clk); #1;
        chk("lb/hold_valid", ld_valid, 0);
        chk("lb/hold_data", ld_data, 32'hFFFF_FF80);
        xfer("lbu", 1'b1, 1'b0, 3'b100, 32'h0000_0203, 32'h0, 32'h80FF_7F01, 0,
             32'h0000_0200, 4'b0000, 32'h0, 32'h0000_0080);
        xfer("lb0", 1'b1, 1'b0, 3'b000, 32'h0000_0200, 32'h0, 32'h80FF_7F01, 0,
             32'h0000_0200, 4'b0000, 32'h0, 32'h0000_0001);
        xfer("lh2", 1'b1, 1'b0, 3'b001, 32'h0000_0302, 32'h0, 32'h80FF_7F01, 1,
             32'h0000_0300, 4'b0000, 32'h0, 32'hFFFF_80FF);
        xfer("lhu0", 1'b1, 1'b0, 3'b101, 32'h0000_0300, 32'h0, 32'h80FF_7F01, 0,
             32'h0000_0300, 4'b0000, 32'h0, 32'h0000_7F01);
        xfer("sh",  1'b0, 1'b1, 3'b001, 32'h0000_0006, 32'h0000_ABCD, 32'h0, 1,
             32'h0000_0004, 4'b1100, 32'hABCD_ABCD, 32'h0);
        xfer("sb",  1'b0, 1'b1, 3'b000, 32'h0000_0001, 32'h1234_5678, 32'h0, 0,
             32'h0000_0000, 4'b0010, 32'h7878_7878, 32'h0);
        xfer("lw",  1'b1, 1'b0, 3'b010, 32'h0000_0010, 32'h0, 32'hCAFE_F00D, 2,
             32'h0000_0010, 4'b0000, 32'h0, 32'hCAFE_F00D);

        illegal("lh_mis", 1'b1, 1'b0, 3'b001, 32'h0000_0005);
        illegal("sw_mis", 1'b0, 1'b1, 3'b010, 32'h0000_0102);
        illegal("both",   1'b1, 1'b1, 3'b010, 32'h0000_0000);
        illegal("ld_011", 1'b1, 1'b0, 3'b011, 32'h0000_0000);
        illegal("st_100", 1'b0, 1'b1, 3'b100, 32'h0000_0000);

        // Bus never answers: four BUSY cycles, then ERR.
        @(negedge clk);
        req_rden = 1'b1; funct3 = 3'b010; addr = 32'h0000_0040; bus_ready = 1'b0;
        #1;
        chk("to/idle_stall", stall, 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            chk("to/busy_req", bus_req, 1);
            chk("to/busy_stall", stall, 1);
        end
        @(negedge clk);
        req_rden = 1'b0;
        #1;
        chk("to/err_fault", fault, 1);
        chk("to/err_stall", stall, 0);
        chk("to/err_req", bus_req, 0);
        chk("to/err_valid", ld_valid, 0);
        @(negedge clk); #1;
        chk("to/idle_fault", fault, 0);
        chk("to/idle_req", bus_req, 0);

        // Reset lands on the second BUSY cycle, request still held.
        @(negedge clk);
        req_rden = 1'b1; funct3 = 3'b010; addr = 32'h0000_0080;
        #1;
        chk("rs/idle_stall", stall, 1);
        @(negedge clk); #1;
        chk("rs/busy1_req", bus_req, 1);
        @(negedge clk); #1;
        chk("rs/busy2_req", bus_req, 1);
        rst = 1'b0;
        #1;
        chk("rs/async_req", bus_req, 0);
        chk("rs/async_stall", stall, 0);
        chk("rs/async_valid", ld_valid, 0);
        chk("rs/async_fault", fault, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rs/fresh_stall", stall, 1);
        chk("rs/fresh_idle_req", bus_req, 0);
        chk("rs/fresh_fault", fault, 0);
        @(negedge clk);
        bus_ready = 1'b1; bus_rdata = 32'h1234_5678;
        #1;
        chk("rs/fresh_busy_req", bus_req, 1);
        chk("rs/fresh_addr", bus_addr, 32'h0000_0080);
        @(negedge clk);
        req_rden = 1'b0; bus_ready = 1'b0; bus_rdata = '0;
        #1;
        chk("rs/fresh_valid", ld_valid, 1);
        chk("rs/fresh_ld", ld_data, 32'h1234_5678);
        chk("rs/fresh_done_stall", stall, 0);
        chk("rs/fresh_done_fault", fault, 0);

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
